ext_trig_multi: RTL
===================

EXT_TRIG_MULTI -- requirements
Module: ext_trig_multi

Interface
REQ-001 Parameter N_CH, default 4: number of trigger/busy channels, 1..16.
REQ-002 Parameter CNT_W, default 32: width of trigger and veto counters.
REQ-003 Parameter DEAD_W, default 16: width of the dead-time setting.
REQ-004 Port clock, input, 1: sole clock; all logic on its rising edge.
REQ-005 Port reset, input, 1: reset, asynchronous, active-high.
REQ-006 Port trig_in, input, N_CH: per-channel trigger levels, already synchronous to clock.
REQ-007 Port busy_in, input, N_CH: per-channel busy levels, synchronous to clock.
REQ-008 Port start_run / stop_run, input, 1 each: run control pulses.
REQ-009 Port ch_mask, input, N_CH: channel enable, 1 = channel participates in trigger and busy.
REQ-010 Port mode, input, 2: 0 = OR, 1 = AND, 2 = majority, 3 = reserved (never triggers).
REQ-011 Port maj_thr, input, 5: majority threshold.
REQ-012 Port dead_time, input, DEAD_W: dead cycles after each accepted trigger.
REQ-013 Port trig_limit, input, CNT_W: accepted triggers per run, 0 = unlimited.
REQ-014 Port trig_delay, input, 5: extra delay of trig_out_dly, 0..31 cycles.
REQ-015 Port running, output, 1: high in RUN or DEAD.
REQ-016 Port trig_out / trig_out_dly, output, 1 each: one-cycle accepted-trigger pulses.
REQ-017 Port trig_count, output, CNT_W: accepted triggers this run.
REQ-018 Port veto_count, output, CNT_W: rejected coincidences this run.

Function
REQ-019 Edge: edge[i] high in cycle t when trig_in[i] is 1 at t and was 0 at t-1; me = edge & ch_mask.
REQ-020 Coincidence: OR = |me; AND = (me == ch_mask) with ch_mask != 0; majority = popcount(me) >= maj_thr with maj_thr != 0.
REQ-021 Busy veto: veto = |(busy_in & ch_mask).
REQ-022 FSM states IDLE, RUN, DEAD; accept = coincidence & state==RUN & !veto & !stop_run.
REQ-023 IDLE -> RUN on start_run & !stop_run; same cycle clears trig_count and veto_count.
REQ-024 start_run in RUN or DEAD is ignored; no counter clear.
REQ-025 RUN -> DEAD on accept; trig_count increments in the same cycle.
REQ-026 DEAD lasts max(dead_time,1) cycles, then -> RUN; dead_time sampled at accept.
REQ-027 RUN or DEAD -> IDLE on stop_run (priority over accept), or when trig_count == trig_limit != 0.
REQ-028 trig_out is registered: high exactly one cycle, the cycle after accept.
REQ-029 trig_out_dly equals trig_out delayed by trig_delay cycles (shift register, 0 = identical); trig_delay changes may drop or duplicate in-flight pulses.
REQ-030 trig_count and veto_count saturate at all-ones, no wrap.
REQ-031 veto_count increments when coincidence & (veto | state==DEAD) while running.
REQ-032 trig_in edge history keeps updating in all states; a level held through DEAD does not retrigger.

Reset
REQ-033 On reset: state IDLE, running 0, trig_out 0, trig_out_dly 0, delay line cleared, counters 0, edge history 0.
REQ-034 Reset mid-run aborts immediately; in-flight delayed pulses are discarded.

Configuration
REQ-035 Macro EXT_TRIG_MULTI_VETO_CNT_EN: defined -> veto_count per REQ-031; undefined -> no counter logic, veto_count tied to 0.

Verification
REQ-036 N_CH=4, mode OR, mask 0001, start, ch0 rising at t -> trig_out at t+1, trig_count 1, DEAD for dead_time=10 cycles.
REQ-037 Mode AND, mask 0011, ch0 edge at t, ch1 at t+1 -> no trigger; both at t+5 -> trig_out at t+6.
REQ-038 Majority, maj_thr=3, edges on 2 then 3 masked channels -> only the 3-channel edge accepted; maj_thr=0 -> none.
REQ-039 busy_in[1]=1, mask 0010, edge on ch1 -> no trig_out, veto_count 1; with mask 0001 busy ignored.
REQ-040 trig_limit=3, 5 spaced edges -> 3 trig_out, running drops after third; start_run clears counts.
REQ-041 trig_delay=7 -> trig_out_dly 7 cycles after trig_out; stop_run with edge same cycle -> no accept.

Source files
------------

// File: rtl/ext_trig_multi_if.sv
// ext_trig_multi_if: trigger control/status bundle; master drives run control, channel levels and settings, slave returns run state, pulses and counters
interface ext_trig_multi_if #(
  parameter int N_CH = 4,
  parameter int CNT_W = 32,
  parameter int DEAD_W = 16
);
  logic [N_CH-1:0] trig_in;
  logic [N_CH-1:0] busy_in;
  logic [N_CH-1:0] ch_mask;
  logic start_run;
  logic stop_run;
  logic [1:0] mode;
  logic [4:0] maj_thr;
  logic [DEAD_W-1:0] dead_time;
  logic [CNT_W-1:0] trig_limit;
  logic [4:0] trig_delay;
  logic running;
  logic trig_out;
  logic trig_out_dly;
  logic [CNT_W-1:0] trig_count;
  logic [CNT_W-1:0] veto_count;
  modport master (
    output trig_in, busy_in, ch_mask, start_run, stop_run, mode, maj_thr, dead_time, trig_limit, trig_delay,
    input running, trig_out, trig_out_dly, trig_count, veto_count
  );
  modport slave (
    input trig_in, busy_in, ch_mask, start_run, stop_run, mode, maj_thr, dead_time, trig_limit, trig_delay,
    output running, trig_out, trig_out_dly, trig_count, veto_count
  );
endinterface

// File: rtl/ext_trig_multi.sv
// ext_trig_multi: multi-channel edge-coincidence trigger with busy veto, dead time, run limit and delayed copy; ports clock, reset (async high), bus (ext_trig_multi_if.slave); define EXT_TRIG_MULTI_VETO_CNT_EN to enable veto_count
module ext_trig_multi #(
  parameter int N_CH = 4,
  parameter int CNT_W = 32,
  parameter int DEAD_W = 16
) (
  input logic clock,
  input logic reset,
  ext_trig_multi_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
  state_t state_q, state_d;
  logic [N_CH-1:0] trig_prev_q, me;
  logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
  logic [CNT_W-1:0] trig_count_q, trig_count_d;
  logic [30:0] dly_q, dly_d;
  logic [4:0] pc, dly_idx;
  logic trig_out_q, coin, veto, halt, accept, clear;
  always_comb begin
    me = bus.trig_in & ~trig_prev_q & bus.ch_mask;
    pc = '0;
    for (int i = 0; i < N_CH; i++) pc = pc + 5'(me[i]);
    coin = bus.mode == 2'd0 ? |me :
           bus.mode == 2'd1 ? (me == bus.ch_mask) && |bus.ch_mask :
           bus.mode == 2'd2 ? (pc >= bus.maj_thr) && |bus.maj_thr : 1'b0;
    veto = |(bus.busy_in & bus.ch_mask);
    clear = state_q == IDLE && bus.start_run && !bus.stop_run;
    halt = bus.stop_run || (trig_count_q == bus.trig_limit && |bus.trig_limit);
    accept = coin && state_q == RUN && !veto && !halt;
    state_d = state_q;
    if (state_q == IDLE) begin
      if (clear) state_d = RUN;
    end else if (halt) state_d = IDLE;
    else if (accept) state_d = DEAD;
    else if (state_q == DEAD && dead_cnt_q == DEAD_W'(1)) state_d = RUN;
    dead_cnt_d = accept ? (|bus.dead_time ? bus.dead_time : DEAD_W'(1)) :
                 state_q == DEAD ? dead_cnt_q - DEAD_W'(1) : dead_cnt_q;
    trig_count_d = clear ? '0 : accept && !(&trig_count_q) ? trig_count_q + CNT_W'(1) : trig_count_q;
    dly_d = {dly_q[29:0], trig_out_q};
    dly_idx = bus.trig_delay - 5'd1;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      trig_prev_q <= '0;
      dead_cnt_q <= '0;
      trig_count_q <= '0;
      trig_out_q <= 1'b0;
      dly_q <= '0;
    end else begin
      state_q <= state_d;
      trig_prev_q <= bus.trig_in;
      dead_cnt_q <= dead_cnt_d;
      trig_count_q <= trig_count_d;
      trig_out_q <= accept;
      dly_q <= dly_d;
    end
  end
  assign bus.running = state_q != IDLE;
  assign bus.trig_out = trig_out_q;
  assign bus.trig_out_dly = bus.trig_delay == 5'd0 ? trig_out_q : dly_q[dly_idx];
  assign bus.trig_count = trig_count_q;
`ifdef EXT_TRIG_MULTI_VETO_CNT_EN
  logic [CNT_W-1:0] veto_count_q, veto_count_d;
  always_comb begin
    veto_count_d = clear ? '0 :
                   state_q != IDLE && coin && (veto || state_q == DEAD) && !(&veto_count_q) ? veto_count_q + CNT_W'(1) :
                   veto_count_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) veto_count_q <= '0;
    else veto_count_q <= veto_count_d;
  end
  assign bus.veto_count = veto_count_q;
`else
  assign bus.veto_count = '0;
`endif
endmodule
